// File: rtl/pcm_rom_loader_pkg.sv
// Shared types for the PCM ROM loader: FSM states, DDR bus widths
// and byte-lane helpers used when packing download bytes into words.
package pcm_rom_loader_pkg;

  localparam int DDR_WORD_W = 64;
  localparam int DDR_BE_W   = 8;
  localparam int DDR_ADDR_W = 29;
  localparam int IO_ADDR_W  = 25;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    WRITE      = 2'd1,
    FLUSH_WAIT = 2'd2
  } state_e;

  function automatic logic [DDR_WORD_W-1:0] put_byte(
    input logic [DDR_WORD_W-1:0] d,
    input logic [2:0]            lane,
    input logic [7:0]            b
  );
    logic [DDR_WORD_W-1:0] r;
    r = d;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [DDR_BE_W-1:0] lane_bit(
    input logic [2:0] lane
  );
    return DDR_BE_W'(1) << lane;
  endfunction

endpackage

// File: rtl/pcm_rom_loader.sv
// pcm_rom_loader: packs the PCM region of the hps_io download into
// 64-bit DDR3 words and writes them through a single-word port.
// Ports:
//   clk_sys, reset_n          clock, async active-low reset
//   ioctl_download/wr/addr/
//   dout/index                hps_io download stream
//   ioctl_wait                stall while a DDR write is outstanding
//   ddr_busy                  DDRAM_BUSY
//   ddr_we/addr/din/be/
//   burstcnt                  single-word Avalon write request
//   loaded                    PCM region fully committed
module pcm_rom_loader
  import pcm_rom_loader_pkg::*;
#(
  parameter logic [DDR_ADDR_W-1:0] BASE_ADDR = 29'h0600000,
  parameter logic [IO_ADDR_W-1:0]  ROM_START = 25'h080000,
  parameter logic [IO_ADDR_W-1:0]  ROM_SIZE  = 25'h040000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [IO_ADDR_W-1:0]  ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic [7:0]            ioctl_index,
  output logic                  ioctl_wait,
  input  logic                  ddr_busy,
  output logic                  ddr_we,
  output logic [DDR_ADDR_W-1:0] ddr_addr,
  output logic [DDR_WORD_W-1:0] ddr_din,
  output logic [DDR_BE_W-1:0]   ddr_be,
  output logic [7:0]            ddr_burstcnt,
  output logic                  loaded
);

  localparam int WORD_W = $clog2(ROM_SIZE / 8);

  typedef logic [WORD_W-1:0] word_t;

  state_e                state_q, state_d;
  logic [DDR_WORD_W-1:0] acc_data_q, acc_data_d;
  logic [DDR_BE_W-1:0]   acc_be_q, acc_be_d;
  word_t                 cur_word_q, cur_word_d;
  logic                  pend_v_q, pend_v_d;
  logic [7:0]            pend_data_q, pend_data_d;
  logic [2:0]            pend_lane_q, pend_lane_d;
  word_t                 pend_word_q, pend_word_d;
  logic                  started_q, started_d;
  logic                  fin_q, fin_d;
  logic                  loaded_q, loaded_d;
  logic                  dl_q;
  logic [DDR_ADDR_W-1:0] addr_q, addr_d;
  logic [DDR_WORD_W-1:0] din_q, din_d;
  logic [DDR_BE_W-1:0]   be_q, be_d;

  // Offset wraps for addresses below ROM_START, so one
  // unsigned compare covers both ends of the window.
  logic [IO_ADDR_W-1:0] off;
  logic                 in_rng;
  logic [2:0]           lane;
  word_t                word;
  logic                 hit;
  logic                 rise;

  assign off    = ioctl_addr - ROM_START;
  assign in_rng = off < ROM_SIZE;
  assign lane   = off[2:0];
  assign word   = off[WORD_W+2:3];
  assign rise   = ioctl_download & ~dl_q;
  assign hit    = ioctl_wr & ioctl_download
                & (ioctl_index == 8'd0) & in_rng;

  // base_*: state after a download restart clears it.
  // eff_*:  base with any held jump byte merged in, so a
  //         byte arriving on the first FILL cycle still
  //         sees the pending byte.
  logic [DDR_WORD_W-1:0] base_data, eff_data, new_data;
  logic [DDR_BE_W-1:0]   base_be, eff_be, new_be;
  word_t                 base_word, eff_word;
  logic                  base_pv, base_started;

  always_comb begin
    base_data    = acc_data_q;
    base_be      = acc_be_q;
    base_word    = cur_word_q;
    base_pv      = pend_v_q;
    base_started = started_q;
    if (rise) begin
      base_data    = '0;
      base_be      = '0;
      base_pv      = 1'b0;
      base_started = 1'b0;
    end

    eff_data = base_data;
    eff_be   = base_be;
    eff_word = base_word;
    if (base_pv) begin
      eff_data = put_byte(base_data, pend_lane_q,
                          pend_data_q);
      eff_be   = base_be | lane_bit(pend_lane_q);
      eff_word = pend_word_q;
    end

    new_data = put_byte(eff_data, lane, ioctl_dout);
    new_be   = eff_be | lane_bit(lane);
  end

  always_comb begin
    state_d     = state_q;
    acc_data_d  = base_data;
    acc_be_d    = base_be;
    cur_word_d  = base_word;
    pend_v_d    = base_pv;
    pend_data_d = pend_data_q;
    pend_lane_d = pend_lane_q;
    pend_word_d = pend_word_q;
    started_d   = base_started;
    fin_d       = rise ? 1'b0 : fin_q;
    loaded_d    = rise ? 1'b0 : loaded_q;
    addr_d      = addr_q;
    din_d       = din_q;
    be_d        = be_q;

    unique case (state_q)
      FILL: begin
        acc_data_d = eff_data;
        acc_be_d   = eff_be;
        cur_word_d = eff_word;
        pend_v_d   = 1'b0;
        if (hit) begin
          started_d = 1'b1;
          if (eff_be != '0 && word != eff_word) begin
            // Address jump: flush the partial word and
            // park the new byte until the write retires.
            addr_d      = BASE_ADDR + DDR_ADDR_W'(eff_word);
            din_d       = eff_data;
            be_d        = eff_be;
            acc_data_d  = '0;
            acc_be_d    = '0;
            pend_v_d    = 1'b1;
            pend_data_d = ioctl_dout;
            pend_lane_d = lane;
            pend_word_d = word;
            state_d     = WRITE;
          end else if (lane == 3'd7) begin
            addr_d     = BASE_ADDR + DDR_ADDR_W'(word);
            din_d      = new_data;
            be_d       = new_be;
            acc_data_d = '0;
            acc_be_d   = '0;
            state_d    = WRITE;
          end else begin
            acc_data_d = new_data;
            acc_be_d   = new_be;
            cur_word_d = word;
          end
        end else if (!ioctl_download && base_started) begin
          if (eff_be != '0) begin
            addr_d     = BASE_ADDR + DDR_ADDR_W'(eff_word);
            din_d      = eff_data;
            be_d       = eff_be;
            acc_data_d = '0;
            acc_be_d   = '0;
            fin_d      = 1'b1;
            state_d    = WRITE;
          end else begin
            loaded_d  = 1'b1;
            started_d = 1'b0;
          end
        end
      end
      WRITE: begin
        if (!ddr_busy) begin
          state_d = FILL;
          if (fin_q) begin
            fin_d     = 1'b0;
            loaded_d  = 1'b1;
            started_d = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FILL;
      acc_data_q  <= '0;
      acc_be_q    <= '0;
      cur_word_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_data_q <= '0;
      pend_lane_q <= '0;
      pend_word_q <= '0;
      started_q   <= 1'b0;
      fin_q       <= 1'b0;
      loaded_q    <= 1'b0;
      dl_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_be_q    <= acc_be_d;
      cur_word_q  <= cur_word_d;
      pend_v_q    <= pend_v_d;
      pend_data_q <= pend_data_d;
      pend_lane_q <= pend_lane_d;
      pend_word_q <= pend_word_d;
      started_q   <= started_d;
      fin_q       <= fin_d;
      loaded_q    <= loaded_d;
      dl_q        <= ioctl_download;
      addr_q      <= addr_d;
      din_q       <= din_d;
      be_q        <= be_d;
    end
  end

  assign ddr_we       = (state_q == WRITE);
  assign ioctl_wait   = (state_q == WRITE);
  assign ddr_addr     = addr_q;
  assign ddr_din      = din_q;
  assign ddr_be       = be_q;
  assign ddr_burstcnt = 8'd1;
  assign loaded       = loaded_q;

endmodule
